// File: rtl/step_clock_pkg.sv
// step_clock_pkg: shared definitions for the step/run clock-enable controller.
//   state_e   : controller state encoding, also driven on the `state` port
//   cnt_width : width of a counter that must reach max(a, b, c) - 1
package step_clock_pkg;

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Returns enough bits to hold values up to the largest argument minus one.
  // The result is never smaller than 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/step_clock_ctrl_input_debounce.sv
// input_debounce: two-flop synchroniser followed by a stability counter.
//   clk, rst : system clock, asynchronous active-low reset
//   din      : raw asynchronous input
//   level    : debounced level. It takes the value of the synchronised input
//              once that input has differed from it for DEBOUNCE_CYCLES
//              consecutive cycles.
// RST_LEVEL is the reset value of both synchroniser flops and of the stable level.
module input_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RST_LEVEL       = 1'b0,
  parameter int   CW              = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every written variable gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignment, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RST_LEVEL;
      sync2_q <= RST_LEVEL;
      level_q <= RST_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: turns a push-button and a run/step switch into a
// single-cycle pipeline advance enable. The enable fires once per debounced
// press in STEP mode, or every RUN_DIV cycles in RUN mode.
//   clk, rst    : system clock, asynchronous active-low reset
//   step_btn_n  : raw button, low = pressed
//   run_sel     : raw switch, 1 = RUN
//   halt_req    : synchronous halt request from the pipeline
//   cpu_en      : one-cycle advance enable (registered)
//   step_count  : number of cpu_en pulses since reset, wraps at 16 bits
//   state       : 0 STEP, 1 RUN, 2 HALT
//   btn_pressed : debounced button level, 1 = pressed
// Optional build macro STEP_AUTOREPEAT_EN: while the button is held in STEP,
// a pulse repeats every REPEAT_CYCLES cycles.
module step_clock_ctrl
  import step_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_btn_n,
  input  logic        run_sel,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic [15:0] step_count,
  output logic [1:0]  state,
  output logic        btn_pressed
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, RUN_DIV, REPEAT_CYCLES);
  localparam logic [CW-1:0] DIV_MAX = CW'(RUN_DIV - 1);

  logic btn_lvl_n, run_lvl;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(1'b1), .CW(CW)) u_btn_db (
    .clk(clk), .rst(rst), .din(step_btn_n), .level(btn_lvl_n)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(1'b0), .CW(CW)) u_run_db (
    .clk(clk), .rst(rst), .din(run_sel), .level(run_lvl)
  );

  state_e        state_q, state_d;
  logic          cpu_en_q, cpu_en_d;
  logic [15:0]   step_count_q, step_count_d;
  logic [CW-1:0] div_q, div_d;
  logic          btn_prev_q, run_prev_q;
  logic          fall_seen_q, fall_seen_d;  // run_sel fell while halted
  logic          press_evt, run_rise, run_fall, div_wrap, rep_fire;

  assign btn_pressed = ~btn_lvl_n;
  assign press_evt   = btn_pressed & ~btn_prev_q;
  assign run_rise    = run_lvl & ~run_prev_q;
  assign run_fall    = ~run_lvl & run_prev_q;
  assign div_wrap    = (div_q == DIV_MAX);

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_MAX = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rep_q, rep_d;

  // Counts only while the button stays held in STEP after the initial press;
  // any release, mode change or halt clears it.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == ST_STEP && !halt_req && !run_rise && btn_pressed && !press_evt) begin
      if (rep_q == REP_MAX) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cpu_en_d    = 1'b0;
    div_d       = div_q;
    fall_seen_d = fall_seen_q;
    unique case (state_q)
      ST_STEP: begin
        if (run_rise) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (press_evt || rep_fire) begin
          cpu_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_fall) begin
          state_d = ST_STEP;
        end else begin
          div_d    = div_wrap ? '0 : div_q + 1'b1;
          cpu_en_d = div_wrap;
        end
      end
      ST_HALT: begin
        if (run_fall) fall_seen_d = 1'b1;
        if (!halt_req) begin
          // The releasing press only leaves HALT; it does not advance the pipeline.
          if (press_evt && !run_lvl) begin
            state_d = ST_STEP;
          end else if (run_rise && fall_seen_q) begin
            state_d     = ST_RUN;
            div_d       = '0;
            fall_seen_d = 1'b0;
          end
        end
      end
      default: state_d = ST_STEP;
    endcase

    // Halt overrides everything, including a press or divider wrap in the same cycle.
    if (halt_req) begin
      state_d  = ST_HALT;
      cpu_en_d = 1'b0;
      if (state_q != ST_HALT) fall_seen_d = 1'b0;
    end

    step_count_d = step_count_q + {15'd0, cpu_en_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_STEP;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
      div_q        <= '0;
      btn_prev_q   <= 1'b0;
      run_prev_q   <= 1'b0;
      fall_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
      div_q        <= div_d;
      btn_prev_q   <= btn_pressed;
      run_prev_q   <= run_lvl;
      fall_seen_q  <= fall_seen_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign step_count = step_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Testbench for step_clock_ctrl with DEBOUNCE_CYCLES = 4 and RUN_DIV = 8.
// Expected pulses (cycle and step_count) are queued by the stimulus; a monitor
// pops one entry for every cpu_en pulse it observes.
module tb_step_clock_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } pulse_t;

  logic        clk, rst, step_btn_n, run_sel, halt_req;
  logic        cpu_en, btn_pressed;
  logic [15:0] step_count;
  logic [1:0]  state;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = 16'd0;
  pulse_t      exp_q[$];

  step_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(DIV), .REPEAT_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .step_btn_n(step_btn_n), .run_sel(run_sel),
    .halt_req(halt_req), .cpu_en(cpu_en), .step_count(step_count),
    .state(state), .btn_pressed(btn_pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue one expected pulse; the model count advances and wraps at 16 bits.
  task automatic expect_pulse(input int at_cyc);
    pulse_t p;
    exp_count = exp_count + 16'd1;
    p.cyc = at_cyc;
    p.cnt = exp_count;
    exp_q.push_back(p);
  endtask

  // Monitor: every observed pulse must match the head of the queue.
  initial begin
    pulse_t e;
    forever begin
      @(negedge clk);
      if (rst && cpu_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_cycle", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_count", int'(step_count), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b0; step_btn_n = 1'b1; run_sel = 1'b0; halt_req = 1'b0;
    tick(2);
    check("rst_state", int'(state), 0);
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_count", int'(step_count), 0);
    check("rst_btn", int'(btn_pressed), 0);
    rst = 1'b1;
    tick(3);

    // 1: clean press held 20 cycles -> pulse 2+4+1 cycles after the edge.
    c = cyc;
    step_btn_n = 1'b0;
    expect_pulse(c + 7);
    tick(5);
    check("btn_before_debounce", int'(btn_pressed), 0);
    tick(1);
    check("btn_after_debounce", int'(btn_pressed), 1);
    tick(14);
    check("s1_count", int'(step_count), 1);
    step_btn_n = 1'b1;
    tick(10);

    // 2: bounce every 2 cycles, then settle pressed.
    c = cyc;
    step_btn_n = 1'b0; tick(2);
    step_btn_n = 1'b1; tick(2);
    step_btn_n = 1'b0; tick(2);
    step_btn_n = 1'b1; tick(2);
    step_btn_n = 1'b0;
    expect_pulse(c + 15);
    tick(12);
    check("s2_count", int'(step_count), 2);
    step_btn_n = 1'b1;
    tick(10);

    // 3: RUN mode; entry at c+7, pulses every 8 cycles from c+15.
    c = cyc;
    run_sel = 1'b1;
    for (int k = 0; k < 4; k++) expect_pulse(c + 15 + 8 * k);
    tick(6);
    check("run_entry_early", int'(state), 0);
    tick(1);
    check("run_entry", int'(state), 1);
    tick(3);
    step_btn_n = 1'b0;           // ignored in RUN
    tick(10);
    step_btn_n = 1'b1;
    tick(26);

    // 4: halt sampled on the edge of the fifth divider wrap (c+47).
    halt_req = 1'b1;
    tick(1);
    check("halt_state", int'(state), 2);
    check("halt_cpu_en", int'(cpu_en), 0);
    check("halt_count", int'(step_count), 6);
    tick(10);
    halt_req = 1'b0;
    run_sel  = 1'b0;
    tick(10);
    check("halt_hold", int'(state), 2);
    step_btn_n = 1'b0;           // leaves HALT, no pulse
    tick(8);
    check("halt_exit_step", int'(state), 0);
    check("halt_exit_count", int'(step_count), 6);
    tick(2);
    step_btn_n = 1'b1;
    tick(10);
    c = cyc;
    step_btn_n = 1'b0;
    expect_pulse(c + 7);
    tick(10);
    check("post_halt_count", int'(step_count), 7);
    step_btn_n = 1'b1;
    tick(10);

    // 5: preload 0xFFFF, one pulse wraps to 0.
    force dut.step_count_q = 16'hFFFF;
    tick(1);
    release dut.step_count_q;
    exp_count = 16'hFFFF;
    check("preload", int'(step_count), 16'hFFFF);
    c = cyc;
    step_btn_n = 1'b0;
    expect_pulse(c + 7);
    tick(10);
    check("wrap_count", int'(step_count), 0);
    step_btn_n = 1'b1;
    tick(10);

    // 6: asynchronous reset mid-RUN, after one pulse.
    c = cyc;
    run_sel = 1'b1;
    expect_pulse(c + 15);
    tick(17);
    check("pre_reset_state", int'(state), 1);
    check("pre_reset_count", int'(step_count), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_count", int'(step_count), 0);
    check("async_rst_cpu_en", int'(cpu_en), 0);
    check("async_rst_btn", int'(btn_pressed), 0);
    exp_count = 16'd0;
    @(negedge clk);
    rst = 1'b1;
    tick(6);
    check("rerun_early", int'(state), 0);
    tick(1);
    check("rerun_entry", int'(state), 1);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
